vga_layer_compositor: RTL and testbench

//  Registered, parametrised VGA pixel compositor. Takes the scan position from the VGA timing generator and
//  NUM_LAYERS rectangle layers (player, obstacles, pickups, bank, ...) and drives RGB with fixed latency and

---
 rtl/vga_layer_compositor_pkg.sv | 19 +
 rtl/vga_rect_hit.sv | 30 +++
 rtl/vga_layer_compositor.sv | 221 ++++++++++++++++++++++
 tb/tb_vga_layer_compositor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_layer_compositor_pkg.sv
// Shared definitions for the VGA layer compositor.
//   flash_state_e : screen-flash FSM states
//   FRAME_CNT_W   : width of the free-running frame counter
//   field_lsb()   : bit offset of layer k's field inside a packed per-layer bus
package vga_layer_compositor_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } flash_state_e;

  localparam int FRAME_CNT_W = 8;
  localparam int RGB_CH      = 3;

  function automatic int field_lsb(input int k, input int field_w);
    return k * field_w;
  endfunction

endpackage

// File: rtl/vga_rect_hit.sv
// Combinational containment test of one scan position against one rectangle.
//   px, py : scan position
//   rx, ry : rectangle top-left corner
//   rw, rh : rectangle width / height (zero gives no hit)
//   en     : rectangle enabled
//   hit    : position lies inside the enabled rectangle
module vga_rect_hit #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  input  logic [COORD_W-1:0] rw,
  input  logic [COORD_W-1:0] rh,
  input  logic               en,
  output logic               hit
);

  // One extra bit so a rectangle reaching past the coordinate range never wraps.
  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, rx} + {1'b0, rw};
  assign y_end = {1'b0, ry} + {1'b0, rh};

  assign hit = en && (px >= rx) && ({1'b0, px} < x_end)
                  && (py >= ry) && ({1'b0, py} < y_end);

endmodule

// File: rtl/vga_layer_compositor.sv
// Registered VGA compositor: NUM_LAYERS priority rectangles over a background,
// per-layer blink, timed screen flash and per-frame collision flags of layer 0.
//   clk, rst            : pixel clock, asynchronous active-low reset
//   x, y, active_pixels : scan position and visible-region flag
//   hsync_in, vsync_in  : syncs from the timing generator
//   frame_start         : one pulse per frame in vertical blanking; latches geometry
//   layer_*             : packed per-layer geometry, enables, blink flags, colours
//   bg_rgb, flash_trig  : background colour, start/restart of the screen flash
//   VGA_*               : RGB and syncs, all delayed by 2 clocks
//   collision, flashing : layer-0 overlaps seen last frame, flash active
module vga_layer_compositor
  import vga_layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int COORD_W      = 10,
  parameter int COLOR_W      = 8,
  parameter int BLINK_BIT    = 4,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COORD_W-1:0]              x,
  input  logic [COORD_W-1:0]              y,
  input  logic                            active_pixels,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            frame_start,
  input  logic [NUM_LAYERS*COORD_W-1:0]   layer_x,
  input  logic [NUM_LAYERS*COORD_W-1:0]   layer_y,
  input  logic [NUM_LAYERS*COORD_W-1:0]   layer_w,
  input  logic [NUM_LAYERS*COORD_W-1:0]   layer_h,
  input  logic [NUM_LAYERS-1:0]           layer_en,
  input  logic [NUM_LAYERS-1:0]           layer_blink,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  input  logic                            flash_trig,
  output logic [COLOR_W-1:0]              VGA_R,
  output logic [COLOR_W-1:0]              VGA_G,
  output logic [COLOR_W-1:0]              VGA_B,
  output logic                            VGA_HS,
  output logic                            VGA_VS,
  output logic                            VGA_BLANK_N,
  output logic [NUM_LAYERS-1:0]           collision,
  output logic                            flashing
);

  localparam int RGB_W  = RGB_CH * COLOR_W;
  localparam int FCNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [FCNT_W-1:0] FLASH_LOAD = FCNT_W'(FLASH_FRAMES);

  // Lowest-index hit wins; background when nothing hits.
  function automatic logic [RGB_W-1:0] pick_rgb(
    input logic [NUM_LAYERS-1:0]       h,
    input logic [NUM_LAYERS*RGB_W-1:0] rgbs,
    input logic [RGB_W-1:0]            bg
  );
    pick_rgb = bg;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (h[k]) pick_rgb = rgbs[field_lsb(k, RGB_W) +: RGB_W];
    end
  endfunction

  function automatic logic [RGB_W-1:0] shade_rgb(
    input logic [RGB_W-1:0] rgb,
    input logic             vis,
    input logic             invert
  );
    if (!vis)        shade_rgb = '0;
    else if (invert) shade_rgb = ~rgb;
    else             shade_rgb = rgb;
  endfunction

  logic [NUM_LAYERS*COORD_W-1:0] sh_x, sh_y, sh_w, sh_h;
  logic [NUM_LAYERS-1:0]         sh_en, sh_blink;
  logic [NUM_LAYERS*RGB_W-1:0]   sh_rgb;
  logic [RGB_W-1:0]              sh_bg;
  logic [FRAME_CNT_W-1:0]        frame_cnt;

  // Geometry shadows change only at frame_start, so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_w      <= '0;
      sh_h      <= '0;
      sh_en     <= '0;
      sh_blink  <= '0;
      sh_rgb    <= '0;
      sh_bg     <= '0;
      frame_cnt <= '0;
    end else if (frame_start) begin
      sh_x      <= layer_x;
      sh_y      <= layer_y;
      sh_w      <= layer_w;
      sh_h      <= layer_h;
      sh_en     <= layer_en;
      sh_blink  <= layer_blink;
      sh_rgb    <= layer_rgb;
      sh_bg     <= bg_rgb;
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  logic [NUM_LAYERS-1:0] hit_raw, hit_p0;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_hit
    localparam int LSB = field_lsb(k, COORD_W);
    vga_rect_hit #(.COORD_W(COORD_W)) u_hit (
      .px  (x),
      .py  (y),
      .rx  (sh_x[LSB +: COORD_W]),
      .ry  (sh_y[LSB +: COORD_W]),
      .rw  (sh_w[LSB +: COORD_W]),
      .rh  (sh_h[LSB +: COORD_W]),
      .en  (sh_en[k]),
      .hit (hit_raw[k])
    );
  end

  assign hit_p0 = hit_raw & ~(sh_blink & {NUM_LAYERS{frame_cnt[BLINK_BIT]}});

  // ---- stage 1: hit vector and delayed control ----
  logic [NUM_LAYERS-1:0] hit_p1;
  logic                  vld_p1, hs_p1, vs_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_p1 <= '0;
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else begin
      hit_p1 <= hit_p0;
      vld_p1 <= active_pixels;
      hs_p1  <= hsync_in;
      vs_p1  <= vsync_in;
    end
  end

  // ---- stage 2: priority select, flash inversion, blanking ----
  logic [RGB_W-1:0] rgb_p1;

  always_comb begin
    rgb_p1 = shade_rgb(pick_rgb(hit_p1, sh_rgb, sh_bg), vld_p1, flashing);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b0;
      VGA_VS      <= 1'b0;
      VGA_BLANK_N <= 1'b0;
    end else begin
      VGA_R       <= rgb_p1[2*COLOR_W +: COLOR_W];
      VGA_G       <= rgb_p1[COLOR_W +: COLOR_W];
      VGA_B       <= rgb_p1[0 +: COLOR_W];
      VGA_HS      <= hs_p1;
      VGA_VS      <= vs_p1;
      VGA_BLANK_N <= vld_p1;
    end
  end

  // Flash: retrigger reloads the counter even when frame_start arrives the same cycle.
  flash_state_e      state;
  logic [FCNT_W-1:0] flash_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      flash_cnt <= '0;
      flashing  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flash_trig) begin
            state     <= ST_FLASH;
            flash_cnt <= FLASH_LOAD;
            flashing  <= 1'b1;
          end
        end
        ST_FLASH: begin
          if (flash_trig) begin
            flash_cnt <= FLASH_LOAD;
          end else if (frame_start) begin
            if (flash_cnt == FCNT_W'(1)) begin
              state     <= ST_IDLE;
              flash_cnt <= '0;
              flashing  <= 1'b0;
            end else begin
              flash_cnt <= flash_cnt - 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Collision term uses the stage-1 hit vector; bit 0 (player vs itself) is never set.
  logic [NUM_LAYERS-1:0] coll_term, coll_acc;

  always_comb begin
    coll_term    = hit_p1 & {NUM_LAYERS{hit_p1[0] & vld_p1}};
    coll_term[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll_acc  <= '0;
      collision <= '0;
    end else if (frame_start) begin
      collision <= coll_acc;
      coll_acc  <= coll_term;
    end else begin
      coll_acc  <= coll_acc | coll_term;
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
module tb_vga_layer_compositor;

  localparam int NL   = 4;
  localparam int CW   = 10;
  localparam int CLW  = 8;
  localparam int BB   = 4;
  localparam int FF   = 30;
  localparam int RGBW = 3 * CLW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CW-1:0]     x = '0, y = '0;
  logic              active_pixels = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic              frame_start = 1'b0, flash_trig = 1'b0;
  logic [NL*CW-1:0]  layer_x = '0, layer_y = '0, layer_w = '0, layer_h = '0;
  logic [NL-1:0]     layer_en = '0, layer_blink = '0;
  logic [NL*RGBW-1:0] layer_rgb = '0;
  logic [RGBW-1:0]   bg_rgb = '0;
  logic [CLW-1:0]    VGA_R, VGA_G, VGA_B;
  logic              VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [NL-1:0]     collision;
  logic              flashing;

  always #5 clk = ~clk;

  vga_layer_compositor #(
    .NUM_LAYERS(NL), .COORD_W(CW), .COLOR_W(CLW), .BLINK_BIT(BB), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .layer_x(layer_x), .layer_y(layer_y), .layer_w(layer_w), .layer_h(layer_h),
    .layer_en(layer_en), .layer_blink(layer_blink), .layer_rgb(layer_rgb),
    .bg_rgb(bg_rgb), .flash_trig(flash_trig),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .collision(collision), .flashing(flashing)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned tag; logic [RGBW-1:0] rgb; logic hs; logic vs; logic bl; } pix_t;
  typedef struct { int unsigned tag; logic [NL-1:0] coll; logic fl; } st_t;
  pix_t pix_q[$];
  st_t  st_q[$];

  // Reference model: what the screen should show, in plain integers.
  int             m_x[NL], m_y[NL], m_w[NL], m_h[NL];
  bit             m_en[NL], m_bl[NL];
  logic [RGBW-1:0] m_rgb[NL];
  logic [RGBW-1:0] m_bg;
  int             m_frame, m_flash_left;
  logic [NL-1:0]  m_acc, m_coll;
  int             lo_x = 80, hi_x = 160, lo_y = 180, hi_y = 260;

  task automatic model_reset();
    for (int k = 0; k < NL; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_w[k] = 0; m_h[k] = 0;
      m_en[k] = 0; m_bl[k] = 0; m_rgb[k] = '0;
    end
    m_bg = '0; m_frame = 0; m_flash_left = 0; m_acc = '0; m_coll = '0;
  endtask

  function automatic bit vis(input int k, input int px, input int py);
    if (!m_en[k]) return 0;
    if (m_bl[k] && (((m_frame >> BB) & 1) == 1)) return 0;
    return px >= m_x[k] && px < m_x[k] + m_w[k] && py >= m_y[k] && py < m_y[k] + m_h[k];
  endfunction

  task automatic set_layer(input int k, input int lx, input int ly, input int lw, input int lh,
                           input bit en, input bit bl, input logic [RGBW-1:0] rgb);
    layer_x[k*CW +: CW] = CW'(lx);
    layer_y[k*CW +: CW] = CW'(ly);
    layer_w[k*CW +: CW] = CW'(lw);
    layer_h[k*CW +: CW] = CW'(lh);
    layer_en[k] = en;
    layer_blink[k] = bl;
    layer_rgb[k*RGBW +: RGBW] = rgb;
  endtask

  // Drive one pixel clock and push what the model expects for it.
  task automatic issue(input int px, input int py, input bit act, input bit fs, input bit trig);
    pix_t p;
    st_t  s;
    int   sel;
    x = CW'(px); y = CW'(py); active_pixels = act;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    frame_start = fs; flash_trig = trig;
    sel = -1;
    for (int k = NL - 1; k >= 0; k--) if (vis(k, px, py)) sel = k;
    p.rgb = (sel < 0) ? m_bg : m_rgb[sel];
    if (m_flash_left > 0) p.rgb = ~p.rgb;
    if (!act) p.rgb = '0;
    p.hs = hsync_in; p.vs = vsync_in; p.bl = act; p.tag = cyc;
    if (act && vis(0, px, py))
      for (int k = 1; k < NL; k++) if (vis(k, px, py)) m_acc[k] = 1'b1;
    if (fs) begin
      m_coll = m_acc; m_acc = '0;
      for (int k = 0; k < NL; k++) begin
        m_x[k] = int'(layer_x[k*CW +: CW]); m_y[k] = int'(layer_y[k*CW +: CW]);
        m_w[k] = int'(layer_w[k*CW +: CW]); m_h[k] = int'(layer_h[k*CW +: CW]);
        m_en[k] = layer_en[k]; m_bl[k] = layer_blink[k]; m_rgb[k] = layer_rgb[k*RGBW +: RGBW];
      end
      m_bg = bg_rgb;
      m_frame = (m_frame + 1) % 256;
    end
    if (trig) m_flash_left = FF;
    else if (fs && m_flash_left > 0) m_flash_left--;
    s.tag = cyc; s.coll = m_coll; s.fl = (m_flash_left > 0);
    pix_q.push_back(p);
    st_q.push_back(s);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int npix, input bit trig, input bit mid_move);
    issue(115, 215, 1, 0, 0);
    issue(135, 235, 1, 0, 0);
    issue(130, 200, 1, 0, 0);
    for (int i = 0; i < npix; i++) begin
      if (mid_move && i == npix / 2) layer_x[0 +: CW] = CW'($urandom_range(0, 200));
      issue($urandom_range(lo_x, hi_x), $urandom_range(lo_y, hi_y), ($urandom % 8) != 0, 0, 0);
    end
    issue(0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0);
    issue(0, 0, 0, 1, trig);
    issue(0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, collision, flashing} !== '0) begin
      errors++;
      $display("FAIL %s: rgb=%h hs=%b vs=%b blank_n=%b coll=%b flashing=%b, all required 0",
               name, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N, collision, flashing);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations as they fall due.
  pix_t mp;
  st_t  ms;
  always @(negedge clk) begin
    if (rst) begin
      if (pix_q.size() > 0 && pix_q[0].tag + 2 == cyc) begin
        mp = pix_q.pop_front();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== mp.rgb || VGA_HS !== mp.hs || VGA_VS !== mp.vs ||
            VGA_BLANK_N !== mp.bl) begin
          errors++;
          $display("FAIL pixel tag=%0d: got rgb=%h hs=%b vs=%b bl=%b, expected rgb=%h hs=%b vs=%b bl=%b",
                   mp.tag, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N,
                   mp.rgb, mp.hs, mp.vs, mp.bl);
        end
      end
      if (st_q.size() > 0 && st_q[0].tag + 1 == cyc) begin
        ms = st_q.pop_front();
        checks++;
        if (collision !== ms.coll || flashing !== ms.fl) begin
          errors++;
          $display("FAIL state tag=%0d: got collision=%b flashing=%b, expected collision=%b flashing=%b",
                   ms.tag, collision, flashing, ms.coll, ms.fl);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b1;

    // Background only: first frame black, then 000080.
    bg_rgb = 24'h000080;
    run_frame(20, 0, 0);
    run_frame(20, 0, 0);

    // Overlapping player/layer-1, including a mid-frame move.
    set_layer(0, 100, 200, 30, 30, 1, 0, 24'hFF0000);
    set_layer(1, 110, 210, 30, 30, 1, 0, 24'h00FF00);
    run_frame(20, 0, 0);
    run_frame(20, 0, 1);
    run_frame(20, 0, 0);
    set_layer(0, 100, 200, 30, 30, 1, 0, 24'hFF0000);

    // Blinking layer 2 and colliding layer 3 over a full frame_cnt wrap.
    set_layer(2, 90, 190, 60, 60, 1, 1, 24'h0000C0);
    set_layer(3, 120, 220, 40, 40, 1, 0, 24'hFFFF00);
    for (int f = 0; f < 270; f++) begin
      if (f == 100) layer_en[3] = 1'b0;
      if (f == 110) layer_en[3] = 1'b1;
      if (f == 120) set_layer(3, 400, 400, 40, 40, 1, 0, 24'hFFFF00);
      if (f == 125) set_layer(3, 120, 220, 40, 40, 1, 0, 24'hFFFF00);
      run_frame(6, 0, 0);
    end

    // Flash, retriggered on a frame_start cycle at frame 20.
    run_frame(6, 1, 0);
    for (int f = 0; f < 55; f++) run_frame(6, f == 19, 0);

    // Random geometry, colours and occasional flash.
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < NL; k++)
        set_layer(k, $urandom_range(60, 180), $urandom_range(160, 280), $urandom_range(0, 60),
                  $urandom_range(0, 60), ($urandom % 4) != 0, 1'($urandom), RGBW'($urandom));
      bg_rgb = RGBW'($urandom);
      run_frame(12, ($urandom % 8) == 0, 0);
    end

    // Rectangles at the edge of the coordinate range must not wrap.
    lo_x = 980; hi_x = 1023; lo_y = 980; hi_y = 1023;
    set_layer(0, 1000, 1000, 40, 40, 1, 0, 24'h123456);
    set_layer(1, 990, 990, 1023, 1023, 1, 0, 24'h654321);
    for (int f = 0; f < 4; f++) run_frame(16, 0, 0);
    lo_x = 80; hi_x = 160; lo_y = 180; hi_y = 260;

    // Asynchronous reset in the middle of active pixels.
    set_layer(0, 100, 200, 30, 30, 1, 0, 24'hFF0000);
    run_frame(6, 1, 0);
    for (int i = 0; i < 5; i++) issue(115, 215, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_zero("mid_frame_reset");
    pix_q.delete();
    st_q.delete();
    model_reset();
    frame_start = 1'b0; flash_trig = 1'b0; active_pixels = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_frame(8, 0, 0);
    run_frame(8, 0, 0);
    run_frame(8, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (pix_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending pixel=%0d state=%0d, required 0 and 0", pix_q.size(), st_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
